tpg: RTL and testbench
======================

Name: tpg

Overview:
- Video test-pattern source feeding the stuffer's pixel-FIFO read interface, directly upstream of it, in place of the capture FIFO.
- Produces 48-bit words (two 24-bit RGB pixels) in raster order, sized from the attr bus.
- Presents first-word-fall-through semantics so the stuffer connects unchanged.

Parameters:
None; all geometry comes from attr.

Ports:
- dpclk  in  1  link-side clock; all logic on rising edge
- reset  in  1  synchronous, active-high
- attr  in  `ATTRMAX+1  mode attributes; uses vact=attr[15:0], hact=attr[31:16]
- en  in  1  generation enable; 0 pauses production
- patsel  in  2  pattern select: 0 colour bars, 1 grey ramp, 2 checkerboard, 3 moving gradient
- fiforden  in  1  read strobe from stuffer; consumes current word when fifoempty=0
- fifodo  out  48  current word; pixel x in [23:0], pixel x+1 in [47:24]; pixel = {R[23:16],G[15:8],B[7:0]}
- fifoempty  out  1  1 = fifodo not valid
- fifosof  out  1  1 while fifodo holds word (x=0,y=0) of a frame
- frame  out  8  frame counter, increments when the last word of a frame is consumed

Behaviour:
- Reset (any cycle, including mid-frame or mid-handshake): fifodo=0, fifoempty=1, fifosof=0, frame=0, x=0, y=0, latched pattern=patsel.
- Internal x steps by 2, range 0..hact-2; y ranges 0..vact-1. hact is required even.
- Single output register, FWFT:
  - If fifoempty=1 and en=1: the word at (x,y) loads next cycle, fifoempty drops to 0, and the position advances.
  - If fifoempty=0 and fiforden=1:
    - with en=1, the next word loads on the next edge (back-to-back, one word per cycle);
    - with en=0, fifoempty rises next cycle.
  - fiforden while fifoempty=1 is ignored.
  - en=0 never invalidates a word already presented.
- First valid word appears on the second cycle after reset deassertion, provided en=1.
- Position advance:
  - x += 2.
  - At x = hact-2: x=0 and y += 1.
  - At y = vact-1 with end of line: y=0.
  - The frame count increments when that last word is consumed by fiforden. frame wraps 255->0.
- patsel is sampled only when generating word (0,0). A change mid-frame takes effect next frame.
- fifosof is registered alongside fifodo, high exactly for the (0,0) word.
- Patterns (px = pixel column, py = row, f = frame):
  - 0, colour bars: bar width W = {hact[15:4],1'b0}. Bar index = px/W, saturating at 7; computed with a running bar counter, no divider.
    - Bar order: FFFFFF, FFFF00, 00FFFF, 00FF00, FF00FF, FF0000, 0000FF, 000000.
    - Both pixels of a word share a bar.
  - 1, ramp: R=G=B=px[7:0].
  - 2, checkerboard: pixel is FFFFFF if px[3]^py[3]^f[0], else 000000.
  - 3, gradient: R=px[7:0]+f, G=py[7:0]+f, B=px[7:0]^py[7:0]; mod-256 arithmetic.
- Degenerate geometry (hact<2 or vact=0): fifoempty held at 1, no words produced.

Test Plan:
- Bars, hact=640, vact=480, en=1, fiforden=1 continuous, after reset:
  - word 0 = 48'hFFFFFFFFFFFF with fifosof=1;
  - word 40 = 48'hFFFF00FFFF00;
  - word 319 = 0;
  - word 320 has x=0, y=1.
- Ramp, words at x=0 / 254 / 256:
  - x=0 -> 48'h010101000000;
  - x=254 -> 48'hFFFFFFFEFEFE;
  - x=256 -> 48'h010101000000.
- Frame wrap: read 153600 words.
  - frame goes 0->1 on the last read;
  - next word has fifosof=1;
  - patsel change made at word 1000 is applied only here.
- Handshake stalls:
  - random fiforden gaps -> fifodo holds stable, no words skipped or duplicated (compare against a model);
  - fiforden while empty -> no position change.
- en control:
  - drop en with a valid word -> word stays until read, then fifoempty=1;
  - re-raise en -> next sequential word appears after 1 cycle.
- Reset mid-frame at y=200:
  - next cycle fifoempty=1, frame=0;
  - first word afterwards is the (0,0) word.

Source files
------------

// File: rtl/tpg_if.sv
// Pixel-FIFO read port between the test-pattern source and the stuffer.
// The source drives the word, empty and start-of-frame flags; the stuffer drives the read strobe.
`ifndef ATTRMAX
`define ATTRMAX 31
`endif

interface tpg_if;
    logic [47:0] fifodo;
    logic        fifoempty;
    logic        fifosof;
    logic        fiforden;

    modport master (output fifodo, output fifoempty, output fifosof, input fiforden);
    modport slave  (input fifodo, input fifoempty, input fifosof, output fiforden);
endinterface

// File: rtl/tpg.sv
// Video test-pattern generator that looks like a first-word-fall-through pixel FIFO.
// Emits two 24-bit RGB pixels per word in raster order, sized by hact/vact from attr.
`ifndef ATTRMAX
`define ATTRMAX 31
`endif

module tpg (
    input  logic              dpclk,
    input  logic              reset,
    input  logic [`ATTRMAX:0] attr,
    input  logic              en,
    input  logic [1:0]        patsel,
    tpg_if.master             fifo,
    output logic [7:0]        frame
);

    logic [15:0] vact;
    logic [15:0] hact;
    logic [15:0] barW;
    logic [15:0] nextCnt;

    logic [15:0] x_q, x_d;
    logic [15:0] y_q, y_d;
    logic [15:0] barCnt_q, barCnt_d;
    logic [2:0]  barIdx_q, barIdx_d;
    logic [1:0]  pat_q, pat_d;
    logic [47:0] do_q, do_d;
    logic        empty_q, empty_d;
    logic        sof_q, sof_d;
    logic        last_q, last_d;
    logic [7:0]  frame_q, frame_d;

    logic [1:0]  patCur;
    logic        geomOk;
    logic        atOrigin;
    logic        eol;
    logic        eof;
    logic        consume;
    logic        load;

    assign vact = attr[15:0];
    assign hact = attr[31:16];
    assign barW = {hact[15:4], 1'b0};

    assign geomOk   = (hact >= 16'd2) && (vact != 16'd0);
    assign atOrigin = (x_q == 16'd0) && (y_q == 16'd0);
    assign eol      = ({1'b0, x_q} + 17'd2) >= {1'b0, hact};
    assign eof      = eol && (({1'b0, y_q} + 17'd1) >= {1'b0, vact});
    assign consume  = !empty_q && fifo.fiforden;
    assign load     = geomOk && en && (empty_q || fifo.fiforden);
    assign patCur   = atOrigin ? patsel : pat_q;
    assign nextCnt  = barCnt_q + 16'd2;
    assign frame_d  = frame_q + {7'd0, consume && last_q};

    function automatic logic [23:0] pixel(input logic [1:0] pat, input logic [7:0] px,
                                          input logic [7:0] py, input logic [7:0] f,
                                          input logic [2:0] bar);
        logic [23:0] c;
        c = 24'h000000;
        case (pat)
            2'd0: begin
                case (bar)
                    3'd0:    c = 24'hFFFFFF;
                    3'd1:    c = 24'hFFFF00;
                    3'd2:    c = 24'h00FFFF;
                    3'd3:    c = 24'h00FF00;
                    3'd4:    c = 24'hFF00FF;
                    3'd5:    c = 24'hFF0000;
                    3'd6:    c = 24'h0000FF;
                    default: c = 24'h000000;
                endcase
            end
            2'd1:    c = {px, px, px};
            2'd2:    c = (px[3] ^ py[3] ^ f[0]) ? 24'hFFFFFF : 24'h000000;
            default: c = {px + f, py + f, px ^ py};
        endcase
        return c;
    endfunction

    // The frame number seen by a new word already includes a completion happening this cycle.
    always_comb begin
        x_d      = x_q;
        y_d      = y_q;
        barCnt_d = barCnt_q;
        barIdx_d = barIdx_q;
        pat_d    = pat_q;
        do_d     = do_q;
        empty_d  = empty_q;
        sof_d    = sof_q;
        last_d   = last_q;
        if (load) begin
            do_d    = {pixel(patCur, x_q[7:0] + 8'd1, y_q[7:0], frame_d, barIdx_q),
                       pixel(patCur, x_q[7:0], y_q[7:0], frame_d, barIdx_q)};
            empty_d = 1'b0;
            sof_d   = atOrigin;
            last_d  = eof;
            pat_d   = patCur;
            if (eol) begin
                x_d      = 16'd0;
                y_d      = eof ? 16'd0 : y_q + 16'd1;
                barCnt_d = 16'd0;
                barIdx_d = 3'd0;
            end else begin
                x_d = x_q + 16'd2;
                if (nextCnt >= barW) begin
                    barCnt_d = 16'd0;
                    barIdx_d = (barIdx_q == 3'd7) ? 3'd7 : barIdx_q + 3'd1;
                end else begin
                    barCnt_d = nextCnt;
                end
            end
        end else if (consume) begin
            empty_d = 1'b1;
        end
    end

    always_ff @(posedge dpclk) begin
        if (reset) begin
            x_q      <= 16'd0;
            y_q      <= 16'd0;
            barCnt_q <= 16'd0;
            barIdx_q <= 3'd0;
            pat_q    <= patsel;
            do_q     <= 48'd0;
            empty_q  <= 1'b1;
            sof_q    <= 1'b0;
            last_q   <= 1'b0;
            frame_q  <= 8'd0;
        end else begin
            x_q      <= x_d;
            y_q      <= y_d;
            barCnt_q <= barCnt_d;
            barIdx_q <= barIdx_d;
            pat_q    <= pat_d;
            do_q     <= do_d;
            empty_q  <= empty_d;
            sof_q    <= sof_d;
            last_q   <= last_d;
            frame_q  <= frame_d;
        end
    end

    assign fifo.fifodo    = do_q;
    assign fifo.fifoempty = empty_q;
    assign fifo.fifosof   = sof_q;
    assign frame          = frame_q;

endmodule

// File: tb/tb_tpg.sv
// Bench for tpg: a word-index reference model checked every cycle, plus directed literal checks.
`ifndef ATTRMAX
`define ATTRMAX 31
`endif

module tb_tpg;

    logic              dpclk = 1'b0;
    logic              reset = 1'b1;
    logic [`ATTRMAX:0] attr;
    logic              en = 1'b0;
    logic [1:0]        patsel = 2'd0;
    logic [7:0]        frame;

    tpg_if fifo ();

    tpg dut (
        .dpclk (dpclk),
        .reset (reset),
        .attr  (attr),
        .en    (en),
        .patsel(patsel),
        .fifo  (fifo.master),
        .frame (frame)
    );

    always #5 dpclk = ~dpclk;

    int total = 0;
    int bad = 0;
    int hact = 640;
    int vact = 480;
    bit checkEn = 1'b0;

    bit          mValid = 1'b0;
    bit          mLast = 1'b0;
    bit          mSof = 1'b0;
    int          mN = 0;
    logic [47:0] mWord = 48'd0;
    logic [7:0]  mFrame = 8'd0;
    logic [1:0]  mPat = 2'd0;

    int          rdCount = 0;
    logic [47:0] capWord [1024];
    bit          capSof [1024];
    logic [7:0]  capFrame [1024];

    task automatic checkOutput(string name, logic [47:0] got, logic [47:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("[TB] FAIL %s: got %h want %h", name, got, want);
        end
    endtask

    // Colour of one pixel straight from the pattern definitions, using a real division for bars.
    function automatic logic [23:0] refPixel(int pat, int px, int py, int f, int h);
        int w, bar;
        logic [7:0] r, g, b;
        case (pat)
            0: begin
                w = (h / 16) * 2;
                bar = px / w;
                if (bar > 7) bar = 7;
                case (bar)
                    0: return 24'hFFFFFF;
                    1: return 24'hFFFF00;
                    2: return 24'h00FFFF;
                    3: return 24'h00FF00;
                    4: return 24'hFF00FF;
                    5: return 24'hFF0000;
                    6: return 24'h0000FF;
                    default: return 24'h000000;
                endcase
            end
            1: begin
                r = 8'(px % 256);
                return {r, r, r};
            end
            2: return ((((px >> 3) ^ (py >> 3) ^ f) & 1) != 0) ? 24'hFFFFFF : 24'h000000;
            default: begin
                r = 8'((px + f) % 256);
                g = 8'((py + f) % 256);
                b = 8'((px ^ py) % 256);
                return {r, g, b};
            end
        endcase
    endfunction

    // Reference: a word index within the frame plus the FIFO valid flag.
    always @(posedge dpclk) begin
        bit consume, gen;
        int wpl, x, y;
        if (reset) begin
            mValid = 1'b0;
            mLast  = 1'b0;
            mSof   = 1'b0;
            mN     = 0;
            mFrame = 8'd0;
            mWord  = 48'd0;
            mPat   = patsel;
        end else begin
            consume = mValid && fifo.fiforden;
            gen = (hact >= 2) && (vact != 0) && en && (!mValid || fifo.fiforden);
            if (consume && mLast) mFrame++;
            if (gen) begin
                wpl = hact / 2;
                x = 2 * (mN % wpl);
                y = mN / wpl;
                if (mN == 0) mPat = patsel;
                mWord  = {refPixel(mPat, x + 1, y, mFrame, hact), refPixel(mPat, x, y, mFrame, hact)};
                mSof   = (mN == 0);
                mLast  = (mN == wpl * vact - 1);
                mValid = 1'b1;
                mN     = mLast ? 0 : mN + 1;
            end else if (consume) begin
                mValid = 1'b0;
            end
        end
    end

    always @(negedge dpclk) begin
        if (checkEn) begin
            checkOutput("fifoempty", {47'd0, fifo.fifoempty}, {47'd0, ~mValid});
            checkOutput("frame", {40'd0, frame}, {40'd0, mFrame});
            if (mValid) begin
                checkOutput("fifodo", fifo.fifodo, mWord);
                checkOutput("fifosof", {47'd0, fifo.fifosof}, {47'd0, mSof});
            end
        end
    end

    // Logs every word that will be consumed on the coming edge.
    always @(negedge dpclk) begin
        if (reset) begin
            rdCount = 0;
        end else if (!fifo.fifoempty && fifo.fiforden) begin
            if (rdCount < 1024) begin
                capWord[rdCount]  = fifo.fifodo;
                capSof[rdCount]   = fifo.fifosof;
                capFrame[rdCount] = frame;
            end
            rdCount++;
        end
    end

    task automatic runCycles(int n);
        repeat (n) @(posedge dpclk);
        #1;
    endtask

    task automatic applyStimulus(bit enV, bit rdV);
        en = enV;
        fifo.fiforden = rdV;
    endtask

    task automatic applyReset(int h, int v, logic [1:0] p);
        @(posedge dpclk);
        #1;
        reset = 1'b1;
        hact = h;
        vact = v;
        attr = {hact[15:0], vact[15:0]};
        patsel = p;
        applyStimulus(1'b0, 1'b0);
        @(posedge dpclk);
        #1;
        reset = 1'b0;
        checkEn = 1'b1;
    endtask

    task automatic waitReads(int target, int budget);
        int c = 0;
        while (rdCount < target && c < budget) begin
            @(posedge dpclk);
            #1;
            c++;
        end
        if (rdCount < target) begin
            total++;
            bad++;
            $display("[TB] FAIL read timeout: got %0d reads want %0d", rdCount, target);
        end
    endtask

    initial begin
        attr = {16'd640, 16'd480};
        fifo.fiforden = 1'b0;

        // Colour bars on 640x480, continuous reads.
        applyReset(640, 480, 2'd0);
        checkOutput("reset empty", {47'd0, fifo.fifoempty}, 48'd1);
        checkOutput("reset frame", {40'd0, frame}, 48'd0);
        checkOutput("reset fifodo", fifo.fifodo, 48'd0);
        checkOutput("reset sof", {47'd0, fifo.fifosof}, 48'd0);
        applyStimulus(1'b1, 1'b0);
        runCycles(1);
        checkOutput("first word empty", {47'd0, fifo.fifoempty}, 48'd0);
        checkOutput("first word data", fifo.fifodo, 48'hFFFFFFFFFFFF);
        applyStimulus(1'b1, 1'b1);
        waitReads(321, 1000);
        checkOutput("bars w0", capWord[0], 48'hFFFFFFFFFFFF);
        checkOutput("bars w0 sof", {47'd0, capSof[0]}, 48'd1);
        checkOutput("bars w40", capWord[40], 48'hFFFF00FFFF00);
        checkOutput("bars w319", capWord[319], 48'h0);
        checkOutput("bars w320", capWord[320], 48'hFFFFFFFFFFFF);
        checkOutput("bars w320 sof", {47'd0, capSof[320]}, 48'd0);

        // Grey ramp.
        applyReset(640, 480, 2'd1);
        applyStimulus(1'b1, 1'b1);
        waitReads(129, 400);
        checkOutput("ramp x0", capWord[0], 48'h010101000000);
        checkOutput("ramp x254", capWord[127], 48'hFFFFFFFEFEFE);
        checkOutput("ramp x256", capWord[128], 48'h010101000000);

        // Frame boundary and deferred pattern change on a 16x4 raster.
        applyReset(16, 4, 2'd1);
        applyStimulus(1'b1, 1'b1);
        waitReads(10, 100);
        patsel = 2'd0;
        waitReads(33, 100);
        checkOutput("midframe pattern", capWord[11], 48'h070707060606);
        checkOutput("last word", capWord[31], 48'h0F0F0F0E0E0E);
        checkOutput("frame before last", {40'd0, capFrame[31]}, 48'd0);
        checkOutput("frame after last", {40'd0, capFrame[32]}, 48'd1);
        checkOutput("new frame sof", {47'd0, capSof[32]}, 48'd1);
        checkOutput("new frame pattern", capWord[32], 48'hFFFFFFFFFFFF);

        // Frame counter wrap with one word per frame.
        applyReset(2, 1, 2'd2);
        applyStimulus(1'b1, 1'b1);
        waitReads(257, 600);
        checkOutput("frame 255", {40'd0, capFrame[255]}, 48'd255);
        checkOutput("frame wrap", {40'd0, capFrame[256]}, 48'd0);

        // en control and reads while empty.
        applyReset(32, 4, 2'd3);
        applyStimulus(1'b1, 1'b0);
        runCycles(1);
        applyStimulus(1'b0, 1'b0);
        runCycles(5);
        checkOutput("en low holds word", {47'd0, fifo.fifoempty}, 48'd0);
        applyStimulus(1'b0, 1'b1);
        runCycles(1);
        checkOutput("en low drains", {47'd0, fifo.fifoempty}, 48'd1);
        runCycles(3);
        applyStimulus(1'b1, 1'b0);
        runCycles(1);
        checkOutput("en resume empty", {47'd0, fifo.fifoempty}, 48'd0);
        checkOutput("en resume word", fifo.fifodo, 48'h030003020002);

        // Reset in the middle of the second frame at y=200.
        applyReset(4, 250, 2'd3);
        applyStimulus(1'b1, 1'b1);
        waitReads(901, 2000);
        reset = 1'b1;
        runCycles(1);
        checkOutput("midreset empty", {47'd0, fifo.fifoempty}, 48'd1);
        checkOutput("midreset frame", {40'd0, frame}, 48'd0);
        reset = 1'b0;
        waitReads(1, 10);
        checkOutput("post reset word", capWord[0], 48'h010001000000);
        checkOutput("post reset sof", {47'd0, capSof[0]}, 48'd1);

        // Degenerate geometry never produces a word.
        applyReset(1, 5, 2'd0);
        applyStimulus(1'b1, 1'b1);
        runCycles(10);
        checkOutput("hact 1 empty", {47'd0, fifo.fifoempty}, 48'd1);
        applyReset(8, 0, 2'd0);
        applyStimulus(1'b1, 1'b1);
        runCycles(10);
        checkOutput("vact 0 empty", {47'd0, fifo.fifoempty}, 48'd1);

        // Random handshake, enable, pattern and occasional reset against the model.
        for (int t = 0; t < 8; t++) begin
            applyReset(2 * int'($urandom_range(8, 40)), int'($urandom_range(1, 6)), 2'($urandom_range(0, 3)));
            for (int c = 0; c < 600; c++) begin
                applyStimulus($urandom_range(0, 3) != 0, $urandom_range(0, 1) != 0);
                patsel = 2'($urandom_range(0, 3));
                reset = ($urandom_range(0, 249) == 0);
                runCycles(1);
            end
            reset = 1'b0;
        end

        checkEn = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
